// File: rtl/ahb_resp_collector_pkg.sv
// ----------------------------------------------------------------------------
// ahb_resp_collector_pkg
//   Shared definitions for the AXI-to-AHB bridge response path.
//   - AXI response codes (OKAY, SLVERR)
//   - default ID / length / response field widths
//   - state encoding of the response-collector FSM
// ----------------------------------------------------------------------------
package ahb_resp_collector_pkg;

  localparam int DEF_ID_W   = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_RESP_W = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PUSH    = 2'd2
  } state_t;

endpackage : ahb_resp_collector_pkg

// File: rtl/ahb_resp_collector.sv
// ----------------------------------------------------------------------------
// ahb_resp_collector
//   Write-side producer for the bridge's ID/response CDC FIFO (wclk domain).
//   Accepts one command (AXI ID, beats-1) per burst, counts completed AHB data
//   phases, ORs their HRESP error bits together and, after the last beat,
//   pushes {id, resp} into the FIFO, waiting as long as the FIFO is full.
//
// Handshakes:
//   command : i_cmd_valid / o_cmd_ready, transfer on the edge where both are 1.
//             o_cmd_ready does not depend on i_cmd_valid.
//   fifo    : o_fifo_write_en is a push strobe, only ever high while
//             i_fifo_full is low; o_fifo_data is registered and held for the
//             whole PUSH state.
//
// Ports:
//   wclk             clock (AHB side)
//   resetn           asynchronous active-low reset
//   i_cmd_valid      command offered by the issuer
//   o_cmd_ready      command accepted when valid & ready
//   i_cmd_id         AXI ID of the burst
//   i_cmd_len        beats-1
//   i_beat_done      1-cycle pulse per completed AHB data phase
//   i_beat_hresp     HRESP of that beat, 1 = ERROR
//   i_fifo_full      full flag of the CDC FIFO
//   o_fifo_write_en  push strobe to the FIFO
//   o_fifo_data      {id, resp}
//   o_busy           high whenever the FSM is not in IDLE
//   o_dbg_state      current FSM state
//   o_err_count      (AHB_RESP_ERR_CNT_EN only) saturating count of pushes
//                    carrying ERR_RESP
//
// Configuration macro: AHB_RESP_ERR_CNT_EN adds o_err_count[15:0].
// ----------------------------------------------------------------------------
module ahb_resp_collector
  import ahb_resp_collector_pkg::*;
#(
  parameter int                ID_W     = DEF_ID_W,
  parameter int                LEN_W    = DEF_LEN_W,
  parameter int                RESP_W   = DEF_RESP_W,
  parameter logic [RESP_W-1:0] ERR_RESP = RESP_W'(RESP_SLVERR)
) (
  input  logic                   wclk,
  input  logic                   resetn,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [ID_W-1:0]        i_cmd_id,
  input  logic [LEN_W-1:0]       i_cmd_len,
  input  logic                   i_beat_done,
  input  logic                   i_beat_hresp,
  input  logic                   i_fifo_full,
  output logic                   o_fifo_write_en,
  output logic [ID_W+RESP_W-1:0] o_fifo_data,
  output logic                   o_busy,
`ifdef AHB_RESP_ERR_CNT_EN
  output logic [15:0]            o_err_count,
`endif
  output logic [1:0]             o_dbg_state
);

  localparam logic [RESP_W-1:0] OKAY_RESP = RESP_W'(RESP_OKAY);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ID_W-1:0]         r_id;
  logic [LEN_W-1:0]        r_remaining;
  logic                    r_err;
  logic [ID_W+RESP_W-1:0]  r_fifo_data;

  logic                    w_accept;
  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_push_fire;
  logic                    w_err_next;

  // Beats only count while collecting; a beat in IDLE (including the accept
  // cycle) or in PUSH is an issuer protocol violation and is dropped.
  assign w_accept    = (r_state == S_IDLE) && i_cmd_valid;
  assign w_beat      = (r_state == S_COLLECT) && i_beat_done;
  assign w_last_beat = w_beat && (r_remaining == '0);
  assign w_push_fire = (r_state == S_PUSH) && !i_fifo_full;
  assign w_err_next  = r_err | i_beat_hresp;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state    = r_state;
    o_cmd_ready     = 1'b0;
    o_fifo_write_en = 1'b0;
    o_busy          = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (w_accept) begin
          w_next_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_last_beat) begin
          w_next_state = S_PUSH;
        end
      end
      S_PUSH: begin
        // Combinational so the push lands in the first cycle full is low.
        o_fifo_write_en = !i_fifo_full;
        if (w_push_fire) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst datapath: ID latch, beats-remaining down-counter, sticky error and
  // the registered FIFO word.
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      r_id        <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_fifo_data <= '0;
    end else begin
      if (w_accept) begin
        r_id        <= i_cmd_id;
        r_remaining <= i_cmd_len;
        r_err       <= 1'b0;
      end
      if (w_beat) begin
        r_err <= w_err_next;
        // Counter stops at zero: the last beat moves to PUSH instead of
        // wrapping, so a 256-beat burst never aliases.
        if (r_remaining != '0) begin
          r_remaining <= r_remaining - LEN_W'(1);
        end
      end
      // The word is built on the last beat so it is already stable on the
      // first PUSH cycle; the final beat's HRESP is folded in directly.
      if (w_last_beat) begin
        r_fifo_data <= {r_id, (w_err_next ? ERR_RESP : OKAY_RESP)};
      end
    end
  end

  assign o_fifo_data = r_fifo_data;
  assign o_dbg_state = r_state;

`ifdef AHB_RESP_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      r_err_count <= '0;
    end else if (w_push_fire && (r_fifo_data[RESP_W-1:0] == ERR_RESP) &&
                 (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_err_count = r_err_count;
`endif

endmodule : ahb_resp_collector

// File: tb/tb_ahb_resp_collector.sv
// ----------------------------------------------------------------------------
// tb_ahb_resp_collector
//   Directed bench for ahb_resp_collector. A transaction-level model tracks
//   "burst in flight", the beat count still owed and the merged error; the
//   expected FIFO words live in exp_q and a negedge compare process checks
//   every cycle. Directed tests also pin literal expected words.
// ----------------------------------------------------------------------------
module tb_ahb_resp_collector;

  localparam int ID_W   = 8;
  localparam int LEN_W  = 8;
  localparam int RESP_W = 2;
  localparam int W      = ID_W + RESP_W;

  logic              wclk;
  logic              resetn;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [ID_W-1:0]   i_cmd_id;
  logic [LEN_W-1:0]  i_cmd_len;
  logic              i_beat_done;
  logic              i_beat_hresp;
  logic              i_fifo_full;
  logic              o_fifo_write_en;
  logic [W-1:0]      o_fifo_data;
  logic              o_busy;
  logic [1:0]        o_dbg_state;
`ifdef AHB_RESP_ERR_CNT_EN
  logic [15:0]       o_err_count;
`endif

  ahb_resp_collector dut (
    .wclk            (wclk),
    .resetn          (resetn),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_id        (i_cmd_id),
    .i_cmd_len       (i_cmd_len),
    .i_beat_done     (i_beat_done),
    .i_beat_hresp    (i_beat_hresp),
    .i_fifo_full     (i_fifo_full),
    .o_fifo_write_en (o_fifo_write_en),
    .o_fifo_data     (o_fifo_data),
    .o_busy          (o_busy),
`ifdef AHB_RESP_ERR_CNT_EN
    .o_err_count     (o_err_count),
`endif
    .o_dbg_state     (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_log[$];
  logic         m_busy;
  logic         m_push;
  logic         m_err;
  logic [ID_W-1:0] m_id;
  int           m_beats_left;
  int           m_err_cnt;

  always @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      m_busy       <= 1'b0;
      m_push       <= 1'b0;
      m_err        <= 1'b0;
      m_id         <= '0;
      m_beats_left <= 0;
      m_err_cnt    <= 0;
      exp_q.delete();
    end else begin
      if (i_beat_done && !(m_busy && !m_push))
        $error("issuer protocol violation: beat_done outside a burst");
      if (!m_busy) begin
        if (i_cmd_valid) begin
          m_busy       <= 1'b1;
          m_id         <= i_cmd_id;
          m_beats_left <= int'(i_cmd_len) + 1;
          m_err        <= 1'b0;
        end
      end else if (!m_push) begin
        if (i_beat_done) begin
          m_err <= m_err | i_beat_hresp;
          m_beats_left <= m_beats_left - 1;
          if (m_beats_left == 1) begin
            m_push <= 1'b1;
            exp_q.push_back({m_id, ((m_err | i_beat_hresp) ? 2'b10 : 2'b00)});
          end
        end
      end else if (!i_fifo_full) begin
        m_push <= 1'b0;
        m_busy <= 1'b0;
        if (exp_q.size() > 0) begin
          if (exp_q[0][1:0] == 2'b10 && m_err_cnt < 65535) m_err_cnt <= m_err_cnt + 1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge wclk) begin
    check("busy", o_busy, m_busy);
    check("cmd_ready", o_cmd_ready, !m_busy);
    check("write_en", o_fifo_write_en, m_push && !i_fifo_full);
    if (o_fifo_write_en && i_fifo_full) check("write_while_full", 1, 0);
    if (m_push) begin
      if (exp_q.size() == 0) check("exp_q_empty", 0, 1);
      else                   check("fifo_data", o_fifo_data, exp_q[0]);
    end
    if (o_fifo_write_en) wr_log.push_back(o_fifo_data);
`ifdef AHB_RESP_ERR_CNT_EN
    check("err_count", o_err_count, m_err_cnt);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic send_cmd(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
    wait_idle();
    i_cmd_valid = 1'b1;
    i_cmd_id    = id;
    i_cmd_len   = len;
    step();
    i_cmd_valid = 1'b0;
    i_cmd_id    = '0;
    i_cmd_len   = '0;
  endtask

  task automatic beat(input logic hresp, input int gap);
    repeat (gap) step();
    i_beat_done  = 1'b1;
    i_beat_hresp = hresp;
    step();
    i_beat_done  = 1'b0;
    i_beat_hresp = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr_before;
    resetn       = 1'b0;
    i_cmd_valid  = 1'b0;
    i_cmd_id     = '0;
    i_cmd_len    = '0;
    i_beat_done  = 1'b0;
    i_beat_hresp = 1'b0;
    i_fifo_full  = 1'b0;
    repeat (3) step();
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_write_en", o_fifo_write_en, 0);
    check("rst_fifo_data", o_fifo_data, 0);
    check("rst_busy", o_busy, 0);
`ifdef AHB_RESP_ERR_CNT_EN
    check("rst_err_count", o_err_count, 0);
`endif
    resetn = 1'b1;
    step();

    // 1: single beat, OKAY -> 10'h0F0 one cycle after the beat
    send_cmd(8'h3C, 8'd0);
    check("t1_ready_low", o_cmd_ready, 0);
    beat(1'b0, 0);
    check("t1_write_en", o_fifo_write_en, 1);
    check("t1_data", o_fifo_data, 10'h0F0);
    step();
    check("t1_idle", o_busy, 0);

    // 2: len=3, error on beat 2 only -> {05, SLVERR}
    send_cmd(8'h05, 8'd3);
    beat(1'b0, 0);
    beat(1'b1, 1);
    beat(1'b0, 0);
    beat(1'b0, 2);
    check("t2_write_en", o_fifo_write_en, 1);
    check("t2_data", o_fifo_data, 10'h016);
    step();
`ifdef AHB_RESP_ERR_CNT_EN
    check("t2_err_count", o_err_count, 1);
`endif

    // 3: FIFO full for 5 cycles in PUSH
    send_cmd(8'hA5, 8'd1);
    beat(1'b0, 0);
    i_fifo_full = 1'b1;
    beat(1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      check("t3_no_write", o_fifo_write_en, 0);
      check("t3_data_hold", o_fifo_data, 10'h294);
      check("t3_busy", o_busy, 1);
      step();
    end
    i_fifo_full = 1'b0;
    #1;
    check("t3_write", o_fifo_write_en, 1);
    check("t3_data", o_fifo_data, 10'h294);
    step();
    check("t3_idle", o_cmd_ready, 1);
    check("t3_no_dup", o_fifo_write_en, 0);

    // 4: 256-beat burst with gaps, error on beat 100
    wr_before = wr_log.size();
    send_cmd(8'h7E, 8'hFF);
    for (int i = 0; i < 255; i++) beat(i == 100, i % 3);
    check("t4_no_early_write", wr_log.size(), wr_before);
    check("t4_ready_low", o_cmd_ready, 0);
    beat(1'b0, 1);
    check("t4_data", o_fifo_data, 10'h1FA);
    step();
    check("t4_one_write", wr_log.size(), wr_before + 1);
`ifdef AHB_RESP_ERR_CNT_EN
    check("t4_err_count", o_err_count, 2);
`endif

    // 5: reset after beat 2 of len=3
    wr_before = wr_log.size();
    send_cmd(8'h99, 8'd3);
    beat(1'b1, 0);
    beat(1'b0, 0);
    resetn = 1'b0;
    #1;
    check("t5_cmd_ready", o_cmd_ready, 1);
    check("t5_write_en", o_fifo_write_en, 0);
    check("t5_fifo_data", o_fifo_data, 0);
    check("t5_busy", o_busy, 0);
`ifdef AHB_RESP_ERR_CNT_EN
    check("t5_err_count", o_err_count, 0);
`endif
    repeat (2) step();
    resetn = 1'b1;
    step();
    check("t5_no_write", wr_log.size(), wr_before);
    send_cmd(8'h42, 8'd0);
    beat(1'b0, 0);
    check("t5_next_data", o_fifo_data, 10'h108);
    check("t5_next_write", o_fifo_write_en, 1);
    step();

    // 6: back-to-back single-beat commands
    wr_before = wr_log.size();
    send_cmd(8'h01, 8'd0);
    beat(1'b0, 0);
    step();
    send_cmd(8'h02, 8'd0);
    beat(1'b0, 0);
    step();
    check("t6_writes", wr_log.size(), wr_before + 2);
    if (wr_log.size() == wr_before + 2) begin
      check("t6_first", wr_log[wr_before], 10'h004);
      check("t6_second", wr_log[wr_before + 1], 10'h008);
    end

    repeat (3) step();
    check("end_exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_ahb_resp_collector
